// File: rtl/poly_tone_synth.sv
// Polyphonic square-wave synthesiser: CHANNELS voices with programmable half-period
// and volume, summed into a registered mix word and converted to a 1-bit PDM stream.
module poly_tone_synth #(
  parameter  int CHANNELS = 4,
  parameter  int PERIOD_W = 12,
  parameter  int VOL_W    = 4,
  localparam int ADDR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int MIX_W    = VOL_W + ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PERIOD_W-1:0] wr_data,
  output logic [CHANNELS-1:0] chan_wave,
  output logic [MIX_W-1:0]    mix_out,
  output logic                pdm_out
);

  localparam logic [1:0] SEL_PERIOD = 2'b00;
  localparam logic [1:0] SEL_VOLUME = 2'b01;
  localparam logic [1:0] SEL_SYNC   = 2'b10;

  logic [PERIOD_W-1:0] period_q [CHANNELS];
  logic [PERIOD_W-1:0] period_d [CHANNELS];
  logic [VOL_W-1:0]    vol_q    [CHANNELS];
  logic [VOL_W-1:0]    vol_d    [CHANNELS];
  logic [PERIOD_W-1:0] cnt_q    [CHANNELS];
  logic [PERIOD_W-1:0] cnt_d    [CHANNELS];
  logic [CHANNELS-1:0] ph_q, ph_d;
  logic [CHANNELS-1:0] addr_hit;
  logic [MIX_W-1:0]    mix_q, mix_d;
  logic [MIX_W-1:0]    acc_q, acc_d;
  logic [MIX_W:0]      acc_sum;
  logic                pdm_q, pdm_d;

  always_comb begin
    addr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      addr_hit[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

  always_comb begin
    period_d = period_q;
    vol_d    = vol_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;

    for (int i = 0; i < CHANNELS; i++) begin
      if (period_q[i] == '0) begin
        cnt_d[i] = '0;
        ph_d[i]  = 1'b0;
      end else if (ena) begin
        if (cnt_q[i] == period_q[i] - PERIOD_W'(1)) begin
          cnt_d[i] = '0;
          ph_d[i]  = ~ph_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
        end
      end

      // A period write restarts the count and suppresses any wrap toggle this cycle.
      if (addr_hit[i] && (wr_sel == SEL_PERIOD)) begin
        period_d[i] = wr_data;
        cnt_d[i]    = '0;
        ph_d[i]     = ph_q[i];
      end else if (addr_hit[i] && (wr_sel == SEL_VOLUME)) begin
        vol_d[i] = wr_data[VOL_W-1:0];
      end

      if (wr_en && (wr_sel == SEL_SYNC)) begin
        cnt_d[i] = '0;
        ph_d[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ph_q[i]) begin
        mix_d = mix_d + MIX_W'(vol_q[i]);
      end
    end
  end

  always_comb begin
    acc_sum = {1'b0, acc_q} + {1'b0, mix_q};
    acc_d   = acc_q;
    pdm_d   = 1'b0;
    if (ena) begin
      acc_d = acc_sum[MIX_W-1:0];
      pdm_d = acc_sum[MIX_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_q[i] <= '0;
        vol_q[i]    <= '0;
        cnt_q[i]    <= '0;
      end
      ph_q  <= '0;
      mix_q <= '0;
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      period_q <= period_d;
      vol_q    <= vol_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      mix_q    <= mix_d;
      acc_q    <= acc_d;
      pdm_q    <= pdm_d;
    end
  end

  assign chan_wave = ph_q;
  assign mix_out   = mix_q;
  assign pdm_out   = pdm_q;

endmodule

// File: tb/tb_poly_tone_synth.sv
// Bench for poly_tone_synth: cycle scoreboard against a behavioural voice model,
// plus a table of single-voice cases and hand-written multi-cycle corner sequences.
module tb_poly_tone_synth;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        wr_en;
  logic        wr_en3;
  logic [1:0]  wr_sel;
  logic [1:0]  wr_addr;
  logic [11:0] wr_data;
  logic [3:0]  cw4;
  logic [5:0]  mix4;
  logic        pdm4;
  logic [2:0]  cw3;
  logic [5:0]  mix3;
  logic        pdm3;

  int n_checks = 0;
  int n_errors = 0;

  poly_tone_synth #(.CHANNELS(4), .PERIOD_W(12), .VOL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .chan_wave(cw4), .mix_out(mix4), .pdm_out(pdm4)
  );

  poly_tone_synth #(.CHANNELS(3), .PERIOD_W(12), .VOL_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en3), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .chan_wave(cw3), .mix_out(mix3), .pdm_out(pdm3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference for the 4-voice instance; expectations queued at each edge.
  typedef struct packed {
    logic [3:0] cw;
    logic [5:0] mix;
    logic       pdm;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       sb_e;
  exp_t       sb_push;
  int         m_p[4];
  int         m_v[4];
  int         m_c[4];
  logic [3:0] m_ph;
  logic [3:0] m_ph_old;
  int         m_mix;
  int         m_acc;
  logic       m_pdm;
  int         m_newmix;
  int         m_sum;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_p[i] = 0; m_v[i] = 0; m_c[i] = 0;
      end
      m_ph = '0; m_mix = 0; m_acc = 0; m_pdm = 1'b0;
    end else begin
      m_newmix = 0;
      for (int i = 0; i < 4; i++) if (m_ph[i]) m_newmix += m_v[i];
      if (ena) begin
        m_sum = m_acc + m_mix;
        m_pdm = (m_sum >= 64);
        m_acc = m_sum % 64;
      end else begin
        m_pdm = 1'b0;
      end
      m_mix = m_newmix;
      m_ph_old = m_ph;
      for (int i = 0; i < 4; i++) begin
        if (m_p[i] == 0) begin
          m_c[i] = 0; m_ph[i] = 1'b0;
        end else if (ena) begin
          m_c[i] = m_c[i] + 1;
          if (m_c[i] >= m_p[i]) begin
            m_c[i] = 0; m_ph[i] = ~m_ph[i];
          end
        end
      end
      if (wr_en) begin
        case (wr_sel)
          2'b00: begin
            m_p[wr_addr] = int'(wr_data);
            m_c[wr_addr] = 0;
            m_ph[wr_addr] = m_ph_old[wr_addr];
          end
          2'b01: m_v[wr_addr] = int'(wr_data[3:0]);
          2'b10: begin
            for (int i = 0; i < 4; i++) m_c[i] = 0;
            m_ph = '0;
          end
          default: ;
        endcase
      end
    end
    sb_push.cw  = m_ph;
    sb_push.mix = 6'(m_mix);
    sb_push.pdm = m_pdm;
    sb_q.push_back(sb_push);
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      chk("scoreboard {wave,mix,pdm}", {21'd0, cw4, mix4, pdm4}, {21'd0, sb_e});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] addr, input logic [11:0] data,
                    input bit to3 = 1'b0);
    wr_sel = sel; wr_addr = addr; wr_data = data;
    if (to3) wr_en3 = 1'b1; else wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0; wr_en3 = 1'b0;
  endtask

  typedef struct {
    int period;
    int vol;
    int exp_first;
    int exp_half;
    int exp_mix;
  } row_t;

  row_t tbl[4];
  int   cnt;
  int   bad;
  int   ones;
  logic [3:0] held;
  logic [3:0] prev_cw;
  logic       prev_b;

  initial begin
    rst_n = 1'b0; ena = 1'b0; wr_en = 1'b0; wr_en3 = 1'b0;
    wr_sel = 2'b00; wr_addr = 2'd0; wr_data = 12'd0;

    tbl[0] = '{period: 5,  vol: 15, exp_first: 5,  exp_half: 5,  exp_mix: 15};
    tbl[1] = '{period: 1,  vol: 8,  exp_first: 1,  exp_half: 1,  exp_mix: 8};
    tbl[2] = '{period: 3,  vol: 7,  exp_first: 3,  exp_half: 3,  exp_mix: 7};
    tbl[3] = '{period: 12, vol: 1,  exp_first: 12, exp_half: 12, exp_mix: 1};

    @(negedge clk);
    chk("reset wave", cw4, 0);
    chk("reset mix", mix4, 0);
    chk("reset pdm", pdm4, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    bad = 0;
    repeat (200) begin
      cyc(1);
      if (cw4 !== 4'd0 || mix4 !== 6'd0 || pdm4 !== 1'b0) bad++;
    end
    chk("idle after reset nonzero cycles", bad, 0);

    for (int r = 0; r < 4; r++) begin
      wr(2'b01, 2'd0, 12'(tbl[r].vol));
      wr(2'b10, 2'd0, 12'd0);
      wr(2'b00, 2'd0, 12'(tbl[r].period));
      chk("row phase after period write", cw4[0], 0);
      cnt = 0;
      do begin
        cyc(1); cnt++;
      end while (cw4[0] !== 1'b1 && cnt < 5000);
      chk("row edges to first toggle", cnt, tbl[r].exp_first);
      chk("row other voices silent", cw4[3:1], 0);
      cnt = 0;
      do begin
        cyc(1); cnt++;
        if (cnt == 1) chk("row mix when high", mix4, tbl[r].exp_mix);
      end while (cw4[0] !== 1'b0 && cnt < 5000);
      chk("row half period", cnt, tbl[r].exp_half);
    end

    wr(2'b01, 2'd0, 12'd8);
    wr(2'b10, 2'd0, 12'd0);
    wr(2'b00, 2'd0, 12'd1);
    cyc(4);
    ones = 0;
    repeat (128) begin
      cyc(1);
      if (pdm4 === 1'b1) ones++;
    end
    chk("pdm ones in 128 within 7..9", (ones >= 7 && ones <= 9), 1);

    for (int i = 0; i < 4; i++) begin
      wr(2'b00, 2'(i), 12'd3);
      wr(2'b01, 2'(i), 12'd15);
    end
    wr(2'b10, 2'd3, 12'hFFF);
    cyc(1);
    prev_cw = cw4;
    bad = 0;
    repeat (24) begin
      cyc(1);
      if (cw4 !== 4'h0 && cw4 !== 4'hF) bad++;
      if (mix4 !== ((prev_cw == 4'hF) ? 6'd60 : 6'd0)) bad++;
      prev_cw = cw4;
    end
    chk("poly sync lockstep violations", bad, 0);

    cyc(4);
    held = cw4;
    ena = 1'b0;
    bad = 0;
    repeat (7) begin
      cyc(1);
      if (cw4 !== held) bad++;
      if (pdm4 !== 1'b0) bad++;
    end
    chk("freeze hold violations", bad, 0);
    ena = 1'b1;

    prev_b = cw4[0];
    cnt = 0;
    do begin
      cyc(1); cnt++;
    end while (cw4[0] === prev_b && cnt < 20);
    chk("collide toggle found", (cnt < 20), 1);
    prev_b = cw4[0];
    cyc(2);
    wr(2'b00, 2'd0, 12'd4);
    chk("collide no toggle on rewrite", cw4[0], prev_b);
    cnt = 0;
    do begin
      cyc(1); cnt++;
    end while (cw4[0] === prev_b && cnt < 5000);
    chk("collide edges to next toggle", cnt, 4);

    wr(2'b00, 2'd3, 12'd2, 1'b1);
    wr(2'b01, 2'd3, 12'd15, 1'b1);
    bad = 0;
    repeat (20) begin
      cyc(1);
      if (cw3 !== 3'd0 || mix3 !== 6'd0) bad++;
    end
    chk("3-voice out-of-range write ignored", bad, 0);
    wr(2'b01, 2'd2, 12'd15, 1'b1);
    wr(2'b00, 2'd2, 12'd2, 1'b1);
    cnt = 0;
    do begin
      cyc(1); cnt++;
    end while (cw3[2] !== 1'b1 && cnt < 50);
    chk("3-voice addr 2 first toggle", cnt, 2);
    cyc(1);
    chk("3-voice addr 2 mix", mix3, 15);

    cyc(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset wave", cw4, 0);
    chk("async reset mix", mix4, 0);
    chk("async reset pdm", pdm4, 0);
    chk("async reset wave 3-voice", cw3, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (50) begin
      cyc(1);
      if (cw4 !== 4'd0 || mix4 !== 6'd0 || pdm4 !== 1'b0 || cw3 !== 3'd0) bad++;
    end
    chk("silence after async reset", bad, 0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
